// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [4:0]  in_rd_address,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [4:0]  rd_address
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_pend_q, rd_pend_d;
  logic [31:0] opa_q, opa_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_q, rd_d;
  logic        valid_q, valid_d;

  logic        signed1, signed2;
  logic [31:0] abs1, abs2;
  logic        div_zero, div_ovf;
  logic [32:0] mul_sum;
  logic [32:0] div_sh, div_diff;
  logic [63:0] prod;
  logic [31:0] dv, dv_n;

  assign busy         = (state_q != IDLE);
  assign stall        = start | busy;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign rd_address   = rd_q;

  always_comb begin
    signed1  = (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    signed2  = (op == OP_MULH) || (op == OP_DIV) ||
               (op == OP_REM);
    abs1     = (signed1 && operand1[31]) ? -operand1
                                         : operand1;
    abs2     = (signed2 && operand2[31]) ? -operand2
                                         : operand2;
    div_zero = (operand2 == 32'd0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (operand1 == 32'h8000_0000) &&
               (operand2 == 32'hFFFF_FFFF);
  end

  // Multiplier lives in acc[31:0] and shifts out as product bits shift in
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} +
               (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    div_sh   = {acc_q[63:32], acc_q[31]};
    div_diff = div_sh - {1'b0, opa_q};
    prod     = neg_q ? -acc_q : acc_q;
    dv       = op_q[1] ? acc_q[63:32] : acc_q[31:0];
    dv_n     = neg_q ? -dv : dv;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_pend_d = rd_pend_q;
    opa_d     = opa_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    result_d  = result_q;
    rd_d      = rd_q;
    valid_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          rd_pend_d = in_rd_address;
          cnt_d     = 5'd0;
          state_d   = CALC;
          unique case (op)
            OP_MULH, OP_DIV: neg_d = operand1[31] ^ operand2[31];
            OP_MULHSU, OP_REM: neg_d = operand1[31];
            default: neg_d = 1'b0;
          endcase
          if (op[2]) begin
            opa_d = abs2;
            acc_d = {32'd0, abs1};
          end else begin
            opa_d = abs1;
            acc_d = {32'd0, abs2};
          end
          // Special divides preload the final value and skip CALC
          if (op[2] && div_zero) begin
            neg_d   = 1'b0;
            acc_d   = op[1] ? {operand1, 32'd0}
                            : {32'd0, 32'hFFFF_FFFF};
            state_d = DONE;
          end else if (div_ovf) begin
            neg_d   = 1'b0;
            acc_d   = op[1] ? 64'd0
                            : {32'd0, 32'h8000_0000};
            state_d = DONE;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          if (div_diff[32])
            acc_d = {div_sh[31:0], acc_q[30:0], 1'b0};
          else
            acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31)
          state_d = DONE;
      end
      DONE: begin
        if (op_q[2])
          result_d = dv_n;
        else if (op_q == OP_MUL)
          result_d = prod[31:0];
        else
          result_d = prod[63:32];
        rd_d    = rd_pend_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = 5'd0;
      valid_d  = 1'b0;
      result_d = result_q;
      rd_d     = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 3'd0;
      rd_pend_q <= 5'd0;
      opa_q     <= 32'd0;
      acc_q     <= 64'd0;
      neg_q     <= 1'b0;
      result_q  <= 32'd0;
      rd_q      <= 5'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_pend_q <= rd_pend_d;
      opa_q     <= opa_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
    end
  end

endmodule
